// File: rtl/iter_cmp.sv
// Multi-cycle comparator: walks the operands MSB-chunk first, CHUNK bits per cycle,
// and stops at the first differing chunk. Result is held until the consumer takes it.
module iter_cmp #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result,
  output logic             eq,
  output logic             lt,
  output logic             ltu,
  output logic             illegal
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("iter_cmp: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, a_shl, b_shl;
  logic [2:0]       sel_q;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] ca, cb, topbit;
  logic             diff, last, c_lt, c_ltu, res_nxt;

  // Operands shift left each cycle so the chunk under test is always the top one.
  if (NCH > 1) begin : g_shift
    assign a_shl = {a_q[WIDTH-CHUNK-1:0], {CHUNK{1'b0}}};
    assign b_shl = {b_q[WIDTH-CHUNK-1:0], {CHUNK{1'b0}}};
  end else begin : g_noshift
    assign a_shl = a_q;
    assign b_shl = b_q;
  end

  always_comb begin
    ca     = a_q[WIDTH-1 -: CHUNK];
    cb     = b_q[WIDTH-1 -: CHUNK];
    topbit = '0;
    // Only the sign-carrying chunk gets its top bit flipped for the signed compare.
    topbit[CHUNK-1] = (idx == IW'(NCH-1));
    diff   = (ca != cb);
    last   = (idx == '0);
    c_ltu  = (ca < cb);
    c_lt   = ((ca ^ topbit) < (cb ^ topbit));
    case (sel_q)
      3'd0:    res_nxt = !diff;
      3'd1:    res_nxt = diff;
      3'd2:    res_nxt = diff && c_lt;
      3'd3:    res_nxt = !(diff && c_lt);
      3'd4:    res_nxt = diff && c_ltu;
      3'd5:    res_nxt = !(diff && c_ltu);
      default: res_nxt = 1'b0;
    endcase
  end

  assign in_ready  = (state == IDLE) && rstn;
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nxt = BUSY;
      BUSY:    if (diff || last)         state_nxt = DONE;
      DONE:    if (out_ready)            state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      idx     <= '0;
      result  <= 1'b0;
      eq      <= 1'b0;
      lt      <= 1'b0;
      ltu     <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q   <= in1;
          b_q   <= in2;
          sel_q <= sel;
          idx   <= IW'(NCH-1);
        end
        BUSY: if (diff || last) begin
          eq      <= !diff;
          lt      <= diff && c_lt;
          ltu     <= diff && c_ltu;
          illegal <= sel_q[2] & sel_q[1];
          result  <= res_nxt;
        end else begin
          a_q <= a_shl;
          b_q <= b_shl;
          idx <= idx - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_cmp.sv
// Bench for iter_cmp: driver pushes model predictions into a queue, a monitor pops and
// compares when out_valid rises and while it is held. A CHUNK=WIDTH build runs alongside.
module tb_iter_cmp;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in1 = '0, in2 = '0;
  logic [2:0]  sel = '0;
  logic        in_ready, out_valid, result, eq, lt, ltu, illegal;

  logic        in_valid_w = 1'b0, out_ready_w = 1'b0;
  logic [31:0] in1_w = '0, in2_w = '0;
  logic [2:0]  sel_w = '0;
  logic        in_ready_w, out_valid_w, result_w, eq_w, lt_w, ltu_w, illegal_w;

  always #5 clk = ~clk;

  iter_cmp #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .eq(eq), .lt(lt), .ltu(ltu), .illegal(illegal));

  iter_cmp #(.WIDTH(32), .CHUNK(32)) dut_w (
    .clk(clk), .rstn(rstn), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .in1(in1_w), .in2(in2_w), .sel(sel_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
    .result(result_w), .eq(eq_w), .lt(lt_w), .ltu(ltu_w), .illegal(illegal_w));

  typedef struct {
    logic res, eq, lt, ltu, ill;
    int   lat;
    int   acc;
  } exp_t;

  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain comparisons; latency is the count of MSB-first chunks up to the first difference.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] s, input int c);
    exp_t        e;
    logic [31:0] d;
    int          n;
    e.eq  = (a == b);
    e.lt  = ($signed(a) < $signed(b));
    e.ltu = (a < b);
    e.ill = (s >= 3'd6);
    case (s)
      3'd0: e.res = e.eq;
      3'd1: e.res = !e.eq;
      3'd2: e.res = e.lt;
      3'd3: e.res = !e.lt;
      3'd4: e.res = e.ltu;
      3'd5: e.res = !e.ltu;
      default: e.res = 1'b0;
    endcase
    d = a ^ b;
    n = 32 / c;
    e.lat = n;
    for (int k = n - 1; k >= 0; k--)
      if ((d >> (32 - (k + 1) * c)) != 0) e.lat = k + 1;
    e.acc = 0;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor
  initial begin
    exp_t cur;
    logic prev_ov = 1'b0, prev_hs = 1'b0;
    cur = '{default: 0};
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_ov = 1'b0;
        prev_hs = 1'b0;
      end else begin
        if (prev_hs) begin
          chk("post_hs_valid", out_valid, 0);
          chk("post_hs_ready", in_ready, 1);
        end
        if (out_valid && !prev_ov) begin
          if (q.size() == 0) chk("unexpected_valid", out_valid, 0);
          else begin
            cur = q.pop_front();
            chk("latency", cyc - cur.acc, cur.lat);
            chk("result", result, cur.res);
            chk("eq", eq, cur.eq);
            chk("lt", lt, cur.lt);
            chk("ltu", ltu, cur.ltu);
            chk("illegal", illegal, cur.ill);
          end
        end else if (out_valid) begin
          chk("hold", {result, eq, lt, ltu, illegal}, {cur.res, cur.eq, cur.lt, cur.ltu, cur.ill});
        end
        prev_hs = out_valid && out_ready;
        prev_ov = out_valid;
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s);
    exp_t e;
    int   n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    chk("send_ready", in_ready, 1);
    in1 = a; in2 = b; sel = s; in_valid = 1'b1;
    tick();
    e = model(a, b, s, 8);
    e.acc = cyc;
    q.push_back(e);
    in_valid = 1'b0;
    in1 = $urandom; in2 = $urandom; sel = 3'($urandom_range(0, 7));
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    out_ready = 1'b0;
    if (n >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got no completion after %0d cycles", n);
    end
  endtask

  logic [31:0] da [6] = '{32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h100, 32'h12345678};
  logic [31:0] db [6] = '{32'h5, 32'h1,        32'h1,        32'h1,        32'h200, 32'h12345678};
  logic [2:0]  ds [6] = '{3'd0,  3'd2,         3'd4,         3'd5,         3'd4,    3'd6};

  initial begin
    exp_t        e;
    logic [31:0] a, b;
    logic [2:0]  s;
    int          n;

    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_outs", {out_valid, result, eq, lt, ltu, illegal}, 0);
    chk("rst_outs_w", {out_valid_w, result_w, eq_w, lt_w, ltu_w, illegal_w}, 0);
    rstn = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);

    for (int i = 0; i < 6; i++) begin
      send(da[i], db[i], ds[i]);
      drain();
    end

    for (int t = 0; t < 60; t++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ (32'h1 << $urandom_range(0, 31));
        2: b = $urandom;
        default: b = a ^ (32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3)));
      endcase
      send(a, b, 3'($urandom_range(0, 7)));
      drain();
    end

    // Consumer stalls for 5 cycles while a new request is offered
    send(32'h80000000, 32'h7FFFFFFF, 3'd3);
    e = model(32'h80000000, 32'h7FFFFFFF, 3'd3, 8);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk("stall_seen", out_valid, 1);
    repeat (5) begin
      in_valid = 1'b1; in1 = $urandom; in2 = $urandom; sel = 3'($urandom_range(0, 7));
      tick();
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_outs", {result, eq, lt, ltu, illegal}, {e.res, e.eq, e.lt, e.ltu, e.ill});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_ready", in_ready, 1);

    // Reset during BUSY discards the operation
    send(32'h0, 32'h0, 3'd0);
    tick();
    rstn = 1'b0;
    #1;
    chk("busy_rst_ready", in_ready, 0);
    tick();
    rstn = 1'b1;
    q.delete();
    #1;
    chk("abort_outs", {out_valid, result, eq, lt, ltu, illegal}, 0);
    chk("abort_ready", in_ready, 1);
    repeat (8) begin
      out_ready = 1'b1;
      tick();
      chk("abort_no_valid", out_valid, 0);
    end
    out_ready = 1'b0;

    // Single-chunk build: every case completes one edge after accept
    for (int t = 0; t < 16; t++) begin
      a = $urandom;
      b = (t % 3 == 0) ? a : ((t % 3 == 1) ? (a ^ 32'h1) : 32'($urandom));
      s = 3'($urandom_range(0, 7));
      chk("w_ready", in_ready_w, 1);
      in1_w = a; in2_w = b; sel_w = s; in_valid_w = 1'b1;
      tick();
      in_valid_w = 1'b0; in1_w = $urandom; in2_w = $urandom;
      chk("w_busy", out_valid_w, 0);
      tick();
      e = model(a, b, s, 32);
      chk("w_lat1_valid", out_valid_w, (e.lat == 1) ? 1 : 0);
      chk("w_outs", {result_w, eq_w, lt_w, ltu_w, illegal_w}, {e.res, e.eq, e.lt, e.ltu, e.ill});
      out_ready_w = 1'b1;
      tick();
      out_ready_w = 1'b0;
      chk("w_release", out_valid_w, 0);
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
    $fatal(1);
  end

endmodule
